alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
- Round-robin scheduler that shares one combinational 4-bit ALU (8 ops: add, sub, not, and, or, xor, compare-less, compare-equal; 3-bit op code) between two requesters.
- Each requester issues operand/op pairs over a valid/ready request channel and receives result, carry and overflow over its own valid/ready response channel.
- Sits between the requester logic and the ALU. It drives the ALU's a/b/ctrl inputs and samples its res/car/of outputs.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- CNT_W, 8, width of the per-requester grant counters (optional feature only).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  scheduler accepts requester 0 this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_op  input  3  requester 0 ALU op code.
- rsp0_valid  output  1  response for requester 0 available.
- rsp0_ready  input  1  requester 0 takes response.
- rsp0_res  output  WIDTH  result.
- rsp0_car, rsp0_of  output  1  carry and overflow flags.
- req1_*/rsp1_*  same set as requester 0, for requester 1.
- alu_a, alu_b  output  WIDTH  ALU operands.
- alu_ctrl  output  3  ALU op code.
- alu_res  input  WIDTH  ALU result.
- alu_car, alu_of  input  1  ALU flags.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- On reset:
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - Latched a/b/op = 0, so alu_a/alu_b/alu_ctrl = 0.
  - Result registers = 0; rsp0_valid = rsp1_valid = 0; busy = 0.
- FSM IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = the only valid requester. If both are valid, grant the one != last_grant.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational from the req valids and last_grant.
  - A ready is never asserted without the matching valid.
  - On handshake: latch a/b/op and owner=N, set last_grant=N, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_ctrl driven from the latched registers, which are held in every state.
  - At the end of the cycle, capture alu_res/alu_car/alu_of unmodified into the result registers; go to RESP.
- RESP:
  - rspN_valid=1 for N==owner only. The other response valid stays 0.
  - rspN_res/car/of come from the result registers and stay stable while valid.
  - On rspN_ready go to IDLE, and rsp valid drops the next cycle.
  - Without ready, hold indefinitely. No new request is accepted.
- Latency and throughput:
  - Request handshake at edge E0 -> EXEC after E0 -> rsp valid after E1.
  - Minimum 3 cycles per operation: IDLE, EXEC, RESP with same-cycle ready.
- Ready/response rules:
  - reqN_ready is 0 in EXEC and RESP regardless of valids.
  - rspN outputs when not valid: hold the last captured values; verification checks them only while valid.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Reset mid-operation (EXEC or RESP): return to IDLE next cycle and drop the pending response, no handshake.
- Arithmetic: none in the block. The ALU outputs pass through bit-exact.

Optional Feature:
- Macro: ALU_SCHED_STATS_EN.
- Defined:
  - Adds outputs gnt0_cnt and gnt1_cnt (CNT_W each).
  - Each increments by 1 on its requester's request handshake and saturates at all-ones (no wrap).
  - Both clear on rst.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles -> all rsp valid 0, busy 0, alu_a/alu_b/alu_ctrl 0.
- Add with carry: req0 a=7, b=9, op=000, rsp0_ready=1 -> rsp0_valid 2 cycles after the handshake, res=0, car=1, of=0. rsp1_valid stays 0.
- Add with overflow: req1 a=4, b=4, op=000 -> rsp1 res=8, car=0, of=1.
- Contention: both requesters valid for 4 operations after reset -> grant order 0,1,0,1. reqN_ready never asserts in EXEC or RESP.
- Backpressure: req0 a=3, b=4, op=000, rsp0_ready=0 for 5 cycles -> rsp0_valid high with res=7 held 5 cycles, req1 not accepted; raise ready -> IDLE next cycle.
- Abort and stats (macro defined):
  - Assert rst during RESP -> rsp valid 0 next cycle and counters 0.
  - Then 260 req0 operations -> gnt0_cnt=255 (saturated), gnt1_cnt=0.

Source files
------------

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between two valid/ready requesters.
// Define ALU_SCHED_STATS_EN to add saturating per-requester grant counters (gnt0_cnt/gnt1_cnt).
module alu_sched #(
    parameter int WIDTH = 4
`ifdef ALU_SCHED_STATS_EN
    , parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_res,
    output logic             rsp0_car,
    output logic             rsp0_of,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_res,
    output logic             rsp1_car,
    output logic             rsp1_of,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_car,
    input  logic             alu_of,

    output logic             busy
`ifdef ALU_SCHED_STATS_EN
    , output logic [CNT_W-1:0] gnt0_cnt
    , output logic [CNT_W-1:0] gnt1_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               car_q, car_d;
    logic               of_q, of_d;

    logic grant;
    logic hs0, hs1;
    logic rsp_done;

    // Requester 1 wins only when requester 0 is idle or requester 0 was served last.
    assign grant = req1_valid & (~req0_valid | ~last_grant_q);
    assign hs0   = (state_q == IDLE) & req0_valid & ~grant;
    assign hs1   = (state_q == IDLE) & req1_valid &  grant;

    assign req0_ready = hs0;
    assign req1_ready = hs1;

    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) &  owner_q;
    assign rsp_done   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

    // Both responders see the same result registers; only the owner's valid qualifies them.
    assign rsp0_res = res_q;
    assign rsp0_car = car_q;
    assign rsp0_of  = of_q;
    assign rsp1_res = res_q;
    assign rsp1_car = car_q;
    assign rsp1_of  = of_q;

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = op_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_d        = res_q;
        car_d        = car_q;
        of_d         = of_q;

        unique case (state_q)
            IDLE: begin
                if (hs0 || hs1) begin
                    a_d          = hs1 ? req1_a  : req0_a;
                    b_d          = hs1 ? req1_b  : req0_b;
                    op_d         = hs1 ? req1_op : req0_op;
                    owner_d      = hs1;
                    last_grant_d = hs1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                car_d   = alu_car;
                of_d    = alu_of;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            res_q        <= '0;
            car_q        <= 1'b0;
            of_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            res_q        <= res_d;
            car_q        <= car_d;
            of_q         <= of_d;
        end
    end

`ifdef ALU_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (hs0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
        if (hs1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign gnt0_cnt = cnt0_q;
    assign gnt1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched; a small combinational ALU model answers the scheduler.
module tb_alu_sched;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [WIDTH-1:0] req0_a, req0_b, rsp0_res;
    logic [2:0]       req0_op;
    logic             rsp0_car, rsp0_of;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [WIDTH-1:0] req1_a, req1_b, rsp1_res;
    logic [2:0]       req1_op;
    logic             rsp1_car, rsp1_of;
    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [2:0]       alu_ctrl;
    logic             alu_car, alu_of;
    logic             busy;
`ifdef ALU_SCHED_STATS_EN
    logic [7:0]       gnt0_cnt, gnt1_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    alu_sched #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_res(rsp0_res), .rsp0_car(rsp0_car), .rsp0_of(rsp0_of),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_res(rsp1_res), .rsp1_car(rsp1_car), .rsp1_of(rsp1_of),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_res(alu_res), .alu_car(alu_car), .alu_of(alu_of),
        .busy(busy)
`ifdef ALU_SCHED_STATS_EN
        , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ALU model: add, sub, not, and, or, xor, less-than, equal.
    always_comb begin
        logic [WIDTH:0] wide;
        wide    = '0;
        alu_res = '0;
        alu_car = 1'b0;
        alu_of  = 1'b0;
        case (alu_ctrl)
            3'd0: begin
                wide    = {1'b0, alu_a} + {1'b0, alu_b};
                alu_res = wide[WIDTH-1:0];
                alu_car = wide[WIDTH];
                alu_of  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'd1: begin
                wide    = {1'b0, alu_a} - {1'b0, alu_b};
                alu_res = wide[WIDTH-1:0];
                alu_car = wide[WIDTH];
                alu_of  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'd2: alu_res = ~alu_a;
            3'd3: alu_res = alu_a & alu_b;
            3'd4: alu_res = alu_a | alu_b;
            3'd5: alu_res = alu_a ^ alu_b;
            3'd6: alu_res = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            default: alu_res = {{(WIDTH-1){1'b0}}, (alu_a == alu_b)};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; rsp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; rsp1_ready = 0;

        // Reset held for two cycles.
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_rsp0_valid", 32'(rsp0_valid), 0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 0);
        check("rst_busy",       32'(busy),       0);
        check("rst_alu_a",      32'(alu_a),      0);
        check("rst_alu_b",      32'(alu_b),      0);
        check("rst_alu_ctrl",   32'(alu_ctrl),   0);
        check("rst_req0_ready_idle", 32'(req0_ready), 0);

        // Add with carry on requester 0: 7 + 9 = 16 -> res 0, car 1, of 0.
        req0_valid = 1; req0_a = 4'd7; req0_b = 4'd9; req0_op = 3'd0; rsp0_ready = 1;
        #1;
        check("add0_req0_ready", 32'(req0_ready), 1);
        check("add0_req1_ready", 32'(req1_ready), 0);
        tick();
        req0_valid = 0;
        #1;
        check("add0_exec_busy",  32'(busy),       1);
        check("add0_exec_alu_a", 32'(alu_a),      7);
        check("add0_exec_alu_b", 32'(alu_b),      9);
        check("add0_exec_ctrl",  32'(alu_ctrl),   0);
        check("add0_exec_rdy",   32'(req0_ready), 0);
        check("add0_exec_rsp",   32'(rsp0_valid), 0);
        tick();
        check("add0_rsp_valid",  32'(rsp0_valid), 1);
        check("add0_rsp_res",    32'(rsp0_res),   0);
        check("add0_rsp_car",    32'(rsp0_car),   1);
        check("add0_rsp_of",     32'(rsp0_of),    0);
        check("add0_rsp1_valid", 32'(rsp1_valid), 0);
        tick();
        check("add0_done_valid", 32'(rsp0_valid), 0);
        check("add0_done_busy",  32'(busy),       0);

        // Add with overflow on requester 1: 4 + 4 = 8 -> res 8, car 0, of 1.
        req1_valid = 1; req1_a = 4'd4; req1_b = 4'd4; req1_op = 3'd0; rsp1_ready = 1;
        #1;
        check("add1_req1_ready", 32'(req1_ready), 1);
        check("add1_req0_ready", 32'(req0_ready), 0);
        tick();
        req1_valid = 0;
        tick();
        check("add1_rsp_valid",  32'(rsp1_valid), 1);
        check("add1_rsp_res",    32'(rsp1_res),   8);
        check("add1_rsp_car",    32'(rsp1_car),   0);
        check("add1_rsp_of",     32'(rsp1_of),    1);
        check("add1_rsp0_valid", 32'(rsp0_valid), 0);
        tick();

        // Contention: req0 xor 1^2=3, req1 and 5&3=1; grants must alternate 0,1,0,1.
        req0_valid = 1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 3'd5; rsp0_ready = 1;
        req1_valid = 1; req1_a = 4'd5; req1_b = 4'd3; req1_op = 3'd3; rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_own;
            exp_own = i[0];
            #1;
            check($sformatf("cont%0d_req0_ready", i), 32'(req0_ready), 32'(!exp_own));
            check($sformatf("cont%0d_req1_ready", i), 32'(req1_ready), 32'(exp_own));
            tick();
            check($sformatf("cont%0d_exec_rdy", i), 32'({req0_ready, req1_ready}), 0);
            tick();
            check($sformatf("cont%0d_resp_rdy", i), 32'({req0_ready, req1_ready}), 0);
            check($sformatf("cont%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(!exp_own));
            check($sformatf("cont%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(exp_own));
            check($sformatf("cont%0d_res", i), 32'(exp_own ? rsp1_res : rsp0_res),
                  exp_own ? 32'd1 : 32'd3);
            tick();
        end
        req0_valid = 0; req1_valid = 0;

        // Backpressure: req0 3+4=7 held while rsp0_ready low; req1 waits.
        req0_valid = 1; req0_a = 4'd3; req0_b = 4'd4; req0_op = 3'd0; rsp0_ready = 0;
        req1_valid = 1;
        #1;
        check("bp_req0_ready", 32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_rsp0_valid", i), 32'(rsp0_valid), 1);
            check($sformatf("bp%0d_rsp0_res", i),   32'(rsp0_res),   7);
            check($sformatf("bp%0d_req1_ready", i), 32'(req1_ready), 0);
            tick();
        end
        rsp0_ready = 1;
        tick();
        check("bp_release_valid", 32'(rsp0_valid), 0);
        check("bp_release_busy",  32'(busy),       0);
        check("bp_release_req1",  32'(req1_ready), 1);
        req1_valid = 0;
        #1;

        // Abort: reset while in RESP drops the pending response.
        req0_valid = 1; req0_a = 4'd2; req0_b = 4'd1; req0_op = 3'd1; rsp0_ready = 0;
        tick();
        req0_valid = 0;
        tick();
        check("abort_rsp_valid", 32'(rsp0_valid), 1);
        check("abort_rsp_res",   32'(rsp0_res),   1);
        rst = 1;
        tick();
        rst = 0;
        check("abort_valid_drop", 32'(rsp0_valid), 0);
        check("abort_busy",       32'(busy),       0);
        check("abort_alu_a",      32'(alu_a),      0);
`ifdef ALU_SCHED_STATS_EN
        check("abort_gnt0_cnt", 32'(gnt0_cnt), 0);
        check("abort_gnt1_cnt", 32'(gnt1_cnt), 0);
`endif
        // After reset requester 0 wins a tie again.
        req0_valid = 1; req1_valid = 1;
        #1;
        check("abort_tie_req0", 32'(req0_ready), 1);
        check("abort_tie_req1", 32'(req1_ready), 0);
        req0_valid = 0; req1_valid = 0;
        #1;

`ifdef ALU_SCHED_STATS_EN
        // 260 requester-0 operations saturate its counter at 255.
        rsp0_ready = 1; req0_a = 4'd1; req0_b = 4'd1; req0_op = 3'd0;
        for (int i = 0; i < 260; i++) begin
            req0_valid = 1;
            tick();
            req0_valid = 0;
            tick();
            tick();
        end
        check("stats_gnt0_sat", 32'(gnt0_cnt), 255);
        check("stats_gnt1_zero", 32'(gnt1_cnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
